score_display_mux: RTL
======================

Name: score_display_mux

Overview:
- Parametrised successor to the maze game's move-score block.
- Counts player moves in packed BCD over DIGITS digits, with saturation.
- Freezes the score on win and keeps a best (lowest) winning score across games.
- Time-multiplexes either score or best onto a DIGITS-digit common-anode 7-segment display. Sits between the maze FSM (move/win/new_game pulses) and the board display pins.

Parameters:
- DIGITS, 4, number of BCD digits and anode lines (1..8).
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2).
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 never blanked); 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- move  in  1  level from maze FSM; each rising edge = one move.
- win  in  1  level; rising edge = player reached exit.
- new_game  in  1  synchronous pulse; starts a new game.
- show_best  in  1  1 = display best score, 0 = current score.
- anode  out  DIGITS  digit enables, active-low, one-hot-low.
- cathode  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- score_bcd  out  4*DIGITS  current score, digit 0 in [3:0].
- best_bcd  out  4*DIGITS  best winning score.
- best_valid  out  1  best_bcd holds a real result.
- won  out  1  game in WON state.

Behaviour:
- Reset (rst=0, async): state PLAY; score_bcd=0, best_bcd=0, best_valid=0, won=0; anode all 1s; cathode 8'hFF; refresh counter and digit index 0; edge-detect registers 0.
- Edge detect: move_q/win_q registered each cycle. move_rise = move & ~move_q; win_rise likewise. A level held high counts once.
- FSM states:
  - PLAY: move_rise increments score by 1 in BCD, carrying digit to digit. At all-9s the score saturates and holds. win_rise -> WON.
  - WON: won=1; move_rise and win_rise ignored.
  - new_game in either state: score=0, state PLAY, won=0. Best is retained.
- Best update on the PLAY->WON transition: if best_valid=0 or final < best_bcd, then best_bcd<=final and best_valid<=1. Packed BCD is compared as an unsigned vector.
- Simultaneous events, same cycle:
  - move_rise + win_rise in PLAY: move counted; final = score+1 (saturated); that value is stored and compared.
  - new_game + any edge: new_game wins; score=0; edges discarded; no best update.
- Score outputs are registered; updated the cycle after the rise is detected, i.e. 2 clk after the input edge.
- Display refresh:
  - Counter runs 0..REFRESH_DIV-1.
  - On wrap, digit index advances modulo DIGITS (DIGITS-1 -> 0).
  - anode[idx]=0, all other bits 1.
  - cathode is registered, 1 clk after the index/source change.
- Digit source: best_bcd when show_best=1, else score_bcd.
  - show_best=1 with best_valid=0: every digit shows dash (8'hBF).
- Decode (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Nibble >9 cannot occur; if forced, decode to 8'hFF.
- Leading-zero blank (BLANK_LZ=1): digit k>0 blanked (segments 7'h7F) if it and all higher digits are 0.
- Decimal point: dp=0 on digit 0 when won=1 and showing the score; otherwise dp=1.
- Reset mid-operation returns everything to reset values immediately, regardless of state.

Test Plan:
- Reset, DIGITS=4, REFRESH_DIV=4: 3 move pulses -> score_bcd=16'h0003.
  - Display: anode cycles E,D,B,7 every 4 clk.
  - cathode=F9? no: digit0 cathode=B0 (showing 3); digits 1-3 = FF (blanked).
- Preload score 16'h0099, one move -> 16'h0100. Preload 16'h9999, 2 moves -> stays 9999.
- Game 1: 5 moves, win -> won=1, best_bcd=0005, best_valid=1; digit0 cathode=12 (dp on).
  - Further move -> score unchanged.
- Game 2: new_game, 7 moves, win -> best stays 0005. Game 3: 2 moves, win -> best=0002.
- show_best=1 before any win -> all digits 8'hBF. Move+win rising same cycle at score 4 -> final 0005.
- move held high 20 cycles -> counts 1. rst low mid-game with won=1 -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/score_display_mux.sv
// rtl/score_display_mux.sv - BCD move score with win freeze, best-score memory and muxed 7-segment drive
module score_display_mux #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  move,
   input  logic                  win,
   input  logic                  new_game,
   input  logic                  show_best,
   output logic [DIGITS-1:0]     anode,
   output logic [7:0]            cathode,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   best_bcd,
   output logic                  best_valid,
   output logic                  won
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {PLAY = 1'b0, WON = 1'b1} state_t;

   state_t                state;
   logic                  move_q, win_q;
   logic                  move_rise, win_rise;
   logic [4*DIGITS-1:0]   score_inc, final_score, src;
   logic                  carry, lz, blank, dp;
   logic [3:0]            nib;
   logic [6:0]            seg;
   logic [7:0]            cath_next;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;

   // Ripple BCD increment; a carry out of the top digit means all 9s, so hold.
   always_comb begin
      score_inc = score_bcd;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (score_bcd[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      if (carry)
         score_inc = score_bcd;
      final_score = move_rise ? score_inc : score_bcd;
   end

   // Rises are registered before use; a new_game in the edge cycle discards them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= PLAY;
         move_q     <= 1'b0;
         win_q      <= 1'b0;
         move_rise  <= 1'b0;
         win_rise   <= 1'b0;
         score_bcd  <= '0;
         best_bcd   <= '0;
         best_valid <= 1'b0;
         won        <= 1'b0;
      end else begin
         move_q    <= move;
         win_q     <= win;
         move_rise <= move & ~move_q & ~new_game;
         win_rise  <= win & ~win_q & ~new_game;
         if (new_game) begin
            score_bcd <= '0;
            state     <= PLAY;
            won       <= 1'b0;
         end else if (state == PLAY) begin
            if (move_rise)
               score_bcd <= score_inc;
            if (win_rise) begin
               state <= WON;
               won   <= 1'b1;
               if (!best_valid || (final_score < best_bcd)) begin
                  best_bcd   <= final_score;
                  best_valid <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      src = show_best ? best_bcd : score_bcd;
      nib = src[4*int'(idx) +: 4];
      lz  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((i >= int'(idx)) && (src[4*i +: 4] != 4'd0))
            lz = 1'b0;
      end
      blank = (BLANK_LZ != 0) && (idx != '0) && lz;
      dp    = ~((idx == '0) && won && !show_best);
      case (nib)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
      if (show_best && !best_valid)
         cath_next = 8'hBF;
      else if (nib > 4'd9)
         cath_next = 8'hFF;
      else if (blank)
         cath_next = {dp, 7'h7F};
      else
         cath_next = {dp, seg};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         idx     <= '0;
         anode   <= '1;
         cathode <= 8'hFF;
      end else begin
         if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            cnt <= cnt + CW'(1);
         end
         anode   <= ~(DIGITS'(1) << idx);
         cathode <= cath_next;
      end
   end

endmodule
